// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory port arbiter
package mem_arb_pkg;

   localparam int MEM_ARB_ADDR_W = 32;
   localparam int MEM_ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_D
   } state_e;

   // Bit positions of the one-hot grant vector produced by the selector
   typedef enum logic {
      REQ_IF,
      REQ_D
   } req_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational priority selector between fetch and data requesters
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       if_req,
   input  logic       d_req,
   input  logic       starve,
   output logic [1:0] gnt
);

   // Data wins (older MEM stage) unless fetch has been starved long enough
   always_comb begin
      gnt = '0;
      if (if_req && (!d_req || starve)) begin
         gnt[REQ_IF] = 1'b1;
      end else if (d_req) begin
         gnt[REQ_D] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported memory; optional fairness via MEM_ARB_FAIR_EN
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = MEM_ARB_ADDR_W,
   parameter int DATA_W       = MEM_ARB_DATA_W,
   parameter int STARVE_LIMIT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);

   state_e     state_q;
   state_e     state_d;
   logic       idle;
   logic       starve;
   logic [1:0] pick_gnt;

   assign idle    = (state_q == IDLE);
   assign mem_req = !idle;

   // Grants are only offered while no transaction is in flight
   mem_arb_pick u_pick (
      .if_req (if_req & idle),
      .d_req  (d_req & idle),
      .starve (starve),
      .gnt    (pick_gnt)
   );

   assign if_gnt = pick_gnt[REQ_IF];
   assign d_gnt  = pick_gnt[REQ_D];

`ifdef MEM_ARB_FAIR_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // Count data grants taken while fetch was waiting; any fetch grant or uncontended data grant clears it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (if_gnt) begin
         starve_cnt <= '0;
      end else if (d_gnt) begin
         starve_cnt <= if_req ? starve_cnt + 1'b1 : '0;
      end
   end
`else
   // Strict data priority: the starve flag can never assert for a legal (non-negative) limit
   assign starve = (STARVE_LIMIT < 0);
`endif

   // Next-state: leave IDLE on a grant, return on the memory acknowledge
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (d_gnt) begin
               state_d = BUSY_D;
            end else if (if_gnt) begin
               state_d = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_D: begin
            if (mem_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the granted payload; it stays stable on mem_* until the acknowledge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else if (d_gnt) begin
         mem_we    <= d_we;
         mem_addr  <= d_addr;
         mem_wdata <= d_wdata;
         mem_be    <= d_we ? d_be : '1;
      end else if (if_gnt) begin
         mem_we    <= 1'b0;
         mem_addr  <= if_addr;
         mem_wdata <= '0;
         mem_be    <= '1;
      end
   end

   // Return one-cycle completions; rdata holds until that requester's next completion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if (mem_ack && state_q == BUSY_IF) begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
         end
         if (mem_ack && state_q == BUSY_D) begin
            d_rvalid <= 1'b1;
            d_rdata  <= mem_we ? '0 : mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0]  exp_d_order;
      logic [31:0] exp_if_rdata_end;
      int g;
`ifdef MEM_ARB_FAIR_EN
      exp_d_order      = 6'b011011;
      exp_if_rdata_end = 32'h22;
`else
      exp_d_order      = 6'b111111;
      exp_if_rdata_end = 32'h11;
`endif

      // reset state
      tick(); tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      reset = 1'b0;
      tick();

      // 1: reset mid-transaction
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      #1 chk("t1_d_gnt", d_gnt, 1);
      tick();
      d_req = 1'b0;
      chk("t1_mem_req", mem_req, 1);
      chk("t1_mem_addr", mem_addr, 32'h40);
      chk("t1_mem_be", mem_be, 4'hf);
      tick();
      #2 reset = 1'b1;
      #1 chk("t1_rst_mem_req", mem_req, 0);
      chk("t1_rst_mem_addr", mem_addr, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("t1_no_rvalid", d_rvalid, 0);
      chk("t1_idle", mem_req, 0);

      // 2: lone fetch, ack two cycles after mem_req
      if_req = 1'b1; if_addr = 32'h0;
      #1 chk("t2_if_gnt", if_gnt, 1);
      chk("t2_d_gnt", d_gnt, 0);
      tick();
      if_req = 1'b0;
      chk("t2_mem_req_t1", mem_req, 1);
      chk("t2_mem_we", mem_we, 0);
      chk("t2_mem_be", mem_be, 4'hf);
      tick();
      chk("t2_mem_req_t2", mem_req, 1);
      chk("t2_no_rvalid_yet", if_rvalid, 0);
      mem_ack = 1'b1; mem_rdata = 32'h20080005;
      tick();
      mem_ack = 1'b0;
      chk("t2_if_rvalid", if_rvalid, 1);
      chk("t2_if_rdata", if_rdata, 32'h20080005);
      chk("t2_mem_req_t3", mem_req, 0);
      tick();
      chk("t2_rvalid_pulse", if_rvalid, 0);
      chk("t2_rdata_hold", if_rdata, 32'h20080005);

      // 3: contention, store wins, fetch granted alongside d_rvalid
      if_req = 1'b1; if_addr = 32'h8;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'hf;
      #1 chk("t3_d_gnt", d_gnt, 1);
      chk("t3_if_gnt_lose", if_gnt, 0);
      tick();
      d_req = 1'b0;
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_addr", mem_addr, 32'h100);
      chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t3_mem_be", mem_be, 4'hf);
      chk("t3_busy_no_gnt", if_gnt, 0);
      mem_ack = 1'b1; mem_rdata = 32'h5555;
      tick();
      mem_ack = 1'b0;
      chk("t3_d_rvalid", d_rvalid, 1);
      chk("t3_d_rdata_store", d_rdata, 0);
      chk("t3_if_gnt_b2b", if_gnt, 1);
      tick();
      if_req = 1'b0;
      chk("t3_fetch_addr", mem_addr, 32'h8);
      chk("t3_fetch_we", mem_we, 0);
      chk("t3_d_rvalid_pulse", d_rvalid, 0);
      mem_ack = 1'b1; mem_rdata = 32'hA;
      tick();
      mem_ack = 1'b0;
      chk("t3_if_rvalid", if_rvalid, 1);
      chk("t3_if_rdata", if_rdata, 32'hA);
      tick();

      // 4: zero-wait memory, continuous fetch
      mem_ack = 1'b1; mem_rdata = 32'h11; if_req = 1'b1; if_addr = 32'h4;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("t4_gnt_%0d", i), if_gnt, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("t4_rvalid_%0d", i), if_rvalid, (i >= 2 && i % 2 == 0) ? 1 : 0);
         tick();
      end
      if_req = 1'b0;
      #1 chk("t4_last_rvalid", if_rvalid, 1);
      chk("t4_no_gnt", if_gnt, 0);
      tick();
      mem_ack = 1'b0;
      chk("t4_rvalid_end", if_rvalid, 0);
      chk("t4_idle", mem_req, 0);

      // 5: both requests held, zero-wait memory: grant order
      mem_ack = 1'b1; mem_rdata = 32'h22;
      if_req = 1'b1; if_addr = 32'hC;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      g = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (i % 2 == 0) begin
            chk($sformatf("t5_d_gnt_%0d", g), d_gnt, exp_d_order[g]);
            chk($sformatf("t5_if_gnt_%0d", g), if_gnt, !exp_d_order[g]);
            g++;
         end else begin
            chk($sformatf("t5_busy_%0d", i), {if_gnt, d_gnt}, 0);
         end
         tick();
      end
      d_req = 1'b0; if_req = 1'b0;
      tick();
      mem_ack = 1'b0;
      chk("t5_d_rdata", d_rdata, 32'h22);

      // 6: stray ack in IDLE
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h1234;
      tick();
      mem_ack = 1'b0;
      chk("t6_if_rvalid", if_rvalid, 0);
      chk("t6_d_rvalid", d_rvalid, 0);
      chk("t6_mem_req", mem_req, 0);
      tick();
      chk("t6_if_rdata", if_rdata, exp_if_rdata_end);
      chk("t6_d_rdata", d_rdata, 32'h22);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
